// File: rtl/pattern_pkg.sv
// pattern_pkg: serializer state encoding and parity helper shared by the serial front-end.
package pattern_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} ser_state_t;
  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/bit_rate_div.sv
// bit_rate_div: free-running 1-of-DIV tick generator, held at zero while clear is high.
module bit_rate_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = !clear && cnt == 8'(DIV - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 8'd1;
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: one-word buffered parallel-to-serial converter with a DIV-cycle bit period.
// Defining BIT_SERIALIZER_PARITY_EN appends an even-parity strobe after every word.
module bit_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             data_out,
  output logic             out_en,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  ser_state_t state, state_nxt;
  logic [WIDTH-1:0] hold, shifter;
  logic [CW-1:0] bit_cnt;
  logic hold_full, tick, accept, last, end_word, load, emit;
  bit_rate_div #(.DIV(DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .clear(state == IDLE),
    .tick(tick)
  );
  assign accept = s_valid && !hold_full;
  assign last   = tick && state == SHIFT && bit_cnt == CW'(WIDTH - 1);
`ifdef BIT_SERIALIZER_PARITY_EN
  logic par_bit;
  assign end_word = tick && state == PAR;
  assign emit     = state == PAR ? par_bit
                  : (MSB_FIRST != 0 ? shifter[WIDTH-1] : shifter[0]);
`else
  assign end_word = last;
  assign emit     = MSB_FIRST != 0 ? shifter[WIDTH-1] : shifter[0];
`endif
  // A held word is taken either from IDLE or seamlessly at the final tick of the current word.
  assign load = hold_full && (state == IDLE || end_word);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
`ifdef BIT_SERIALIZER_PARITY_EN
    state_nxt = (state == IDLE || end_word) ? (hold_full ? SHIFT : IDLE)
              : last ? PAR : state;
`else
    state_nxt = (state == IDLE || end_word) ? (hold_full ? SHIFT : IDLE) : state;
`endif
  end
  always_comb begin
    s_ready = !hold_full;
    busy    = state != IDLE || hold_full;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= s_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      shifter  <= '0;
      bit_cnt  <= '0;
      data_out <= 1'b0;
      out_en   <= 1'b0;
    end else begin
      out_en <= tick;
      if (tick) data_out <= emit;
      if (load) begin
        shifter <= hold;
        bit_cnt <= '0;
      end else if (tick && state == SHIFT) begin
        shifter <= MSB_FIRST != 0 ? shifter << 1 : shifter >> 1;
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
`ifdef BIT_SERIALIZER_PARITY_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_bit <= 1'b0;
    else if (load) par_bit <= parity(32'(hold));
`endif
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: four differently parameterised serializers against a strobe-schedule model.
module tb_bit_serializer;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  localparam int NI = 4, DEPTH = 8192;
  localparam int WS [NI] = '{4, 8, 8, 4};
  localparam int DS [NI] = '{1, 1, 3, 1};
  localparam int MS [NI] = '{1, 1, 1, 0};
  logic clk = 1'b0;
  logic [NI-1:0] rst, s_valid, s_ready, data_out, out_en, busy;
  logic [31:0] s_data [NI];
  int tests = 0, fails = 0, cyc = 0;
  bit exp_en [NI][DEPTH];
  bit exp_bit [NI][DEPTH];
  int t_last [NI] = '{default: 0};
  int hold_rel [NI] = '{default: 0};
  int acc_cyc [NI] = '{default: -1};
  int first_en [NI] = '{default: -1};
  int ocnt [NI] = '{default: 0};
  bit acc [NI];
  bit cur_d [NI];
  logic [63:0] obs [NI] = '{default: '0};
  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(1)) u0 (.clk(clk), .rst(rst[0]),
    .s_data(s_data[0][3:0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .data_out(data_out[0]), .out_en(out_en[0]), .busy(busy[0]));
  bit_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1)) u1 (.clk(clk), .rst(rst[1]),
    .s_data(s_data[1][7:0]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .data_out(data_out[1]), .out_en(out_en[1]), .busy(busy[1]));
  bit_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1)) u2 (.clk(clk), .rst(rst[2]),
    .s_data(s_data[2][7:0]), .s_valid(s_valid[2]), .s_ready(s_ready[2]),
    .data_out(data_out[2]), .out_en(out_en[2]), .busy(busy[2]));
  bit_serializer #(.WIDTH(4), .DIV(1), .MSB_FIRST(0)) u3 (.clk(clk), .rst(rst[3]),
    .s_data(s_data[3][3:0]), .s_valid(s_valid[3]), .s_ready(s_ready[3]),
    .data_out(data_out[3]), .out_en(out_en[3]), .busy(busy[3]));

  task automatic check(input string name, input int i, input logic [63:0] act, input logic [63:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", name, i, act, exp_v, cyc);
    end
  endtask

  // A word accepted at edge a starts at max(a+1, end of previous word); its strobes follow every DIV edges.
  task automatic schedule(input int i, input logic [31:0] raw);
    logic [31:0] w;
    int n, l;
    w = raw & 32'((64'd1 << WS[i]) - 1);
    n = WS[i] + PE;
    l = (cyc + 1 > t_last[i]) ? cyc + 1 : t_last[i];
    for (int k = 1; k <= n; k++) begin
      exp_en[i][l + DS[i] * k]  = 1'b1;
      exp_bit[i][l + DS[i] * k] = k > WS[i] ? ^w : (MS[i] != 0 ? w[WS[i] - k] : w[k - 1]);
    end
    t_last[i] = l + DS[i] * n;
    hold_rel[i] = l;
    acc[i] = 1'b1;
    if (acc_cyc[i] < 0) acc_cyc[i] = cyc;
  endtask

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < NI; i++) begin
      acc[i] = 1'b0;
      if (!rst[i]) begin
        for (int k = cyc; k < DEPTH; k++) exp_en[i][k] = 1'b0;
        t_last[i] = 0;
        hold_rel[i] = 0;
      end else if (s_valid[i] && cyc > hold_rel[i]) begin
        schedule(i, s_data[i]);
      end
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      if (!rst[i]) cur_d[i] = 1'b0;
      else if (exp_en[i][cyc]) cur_d[i] = exp_bit[i][cyc];
      check("out_en", i, out_en[i], rst[i] && exp_en[i][cyc]);
      check("data_out", i, data_out[i], cur_d[i]);
      check("s_ready", i, s_ready[i], cyc >= hold_rel[i]);
      check("busy", i, busy[i], cyc < t_last[i]);
      if (out_en[i]) begin
        obs[i] = {obs[i][62:0], data_out[i]};
        ocnt[i]++;
        if (first_en[i] < 0) first_en[i] = cyc;
      end
    end
  end

  initial begin
    logic [31:0] dq [NI][$];
    logic [63:0] lit [NI];
    int nb [NI];
    int lat [NI];
    int base;
    rst = '0;
    s_valid = '0;
    for (int i = 0; i < NI; i++) s_data[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("reset_s_ready", i, s_ready[i], 1);
      check("reset_busy", i, busy[i], 0);
      check("reset_out_en", i, out_en[i], 0);
      check("reset_data_out", i, data_out[i], 0);
    end
    rst = '1;
    dq[0].push_back(32'h0000000A);
    dq[1].push_back(32'h000000A5);
    dq[1].push_back(32'h0000003C);
    dq[1].push_back(32'h00000007);
    dq[1].push_back(32'h00000003);
    dq[2].push_back(32'h000000FF);
    dq[3].push_back(32'h00000001);
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < NI; i++) begin
        s_valid[i] = dq[i].size() > 0;
        s_data[i]  = s_valid[i] ? dq[i][0] : '0;
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) if (acc[i]) void'(dq[i].pop_front());
    end
    s_valid = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
    nb  = '{5, 36, 9, 5};
    lit = '{64'b10100, 64'b101001010_001111000_000001111_000000110, 64'b111111110, 64'b10001};
`else
    nb  = '{4, 32, 8, 4};
    lit = '{64'b1010, 64'hA53C0703, 64'hFF, 64'b1000};
`endif
    lat = '{2, 2, 4, 2};
    for (int i = 0; i < NI; i++) begin
      check("directed_count", i, ocnt[i], nb[i]);
      check("directed_bits", i, obs[i] & ((64'd1 << nb[i]) - 1), lit[i]);
      check("first_latency", i, first_en[i] - acc_cyc[i], lat[i]);
    end
    base = ocnt[1];
    s_valid[1] = 1'b1;
    s_data[1]  = 32'h000000C3;
    @(negedge clk);
    s_valid[1] = 1'b0;
    for (int c = 0; c < 20 && ocnt[1] < base + 3; c++) @(negedge clk);
    check("mid_strobes", 1, ocnt[1] - base, 3);
    rst[1] = 1'b0;
    #1;
    check("mid_reset_out_en", 1, out_en[1], 0);
    check("mid_reset_s_ready", 1, s_ready[1], 1);
    check("mid_reset_busy", 1, busy[1], 0);
    repeat (2) @(negedge clk);
    rst[1] = 1'b1;
    base = ocnt[1];
    repeat (20) @(negedge clk);
    check("post_reset_strobes", 1, ocnt[1] - base, 0);
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (!s_valid[i] || acc[i]) begin
          s_valid[i] = $urandom_range(0, 99) < (c < 1000 ? 90 : 30);
          s_data[i]  = $urandom;
        end
        rst[i] = $urandom_range(0, 299) != 0;
      end
      @(negedge clk);
    end
    s_valid = '0;
    rst = '1;
    repeat (100) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
